// File: rtl/osiris_pkg.sv
// ---------------------------------------------------------------------------
// osiris_pkg
// Shared definitions for the Osiris two-master Wishbone memory arbiter.
//   - default bus widths and timeout
//   - master index constants (bit positions in the one-hot grant vector)
//   - arbiter FSM state encoding
//   - saturating 8-bit increment helper for the timeout event counter
// ---------------------------------------------------------------------------
package osiris_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Bit positions in the one-hot grant vector.
  localparam int unsigned GNT_CORE = 0;
  localparam int unsigned GNT_UART = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StErr  = 2'd2
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/osiris_rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// osiris_rr_arbiter_2
// Pure combinational two-way round-robin pick.
// Ports:
//   i_req  [1:0]  request vector, bit GNT_CORE = core, bit GNT_UART = UART
//   i_last        index of the master granted most recently (0 core, 1 UART)
//   o_gnt  [1:0]  one-hot pick, 00 when nothing is requested
// A single requester always wins; on a tie the master that was not granted
// last wins.
// ---------------------------------------------------------------------------
module osiris_rr_arbiter_2
  import osiris_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  logic [1:0] w_core_oh;
  logic [1:0] w_uart_oh;

  always_comb begin
    w_core_oh           = 2'b00;
    w_core_oh[GNT_CORE] = 1'b1;
    w_uart_oh           = 2'b00;
    w_uart_oh[GNT_UART] = 1'b1;
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[GNT_CORE] && i_req[GNT_UART]) begin
      o_gnt = (i_last == 1'(GNT_UART)) ? w_core_oh : w_uart_oh;
    end else if (i_req[GNT_CORE]) begin
      o_gnt = w_core_oh;
    end else if (i_req[GNT_UART]) begin
      o_gnt = w_uart_oh;
    end
  end

endmodule

// File: rtl/osiris_mem_arbiter.sv
// ---------------------------------------------------------------------------
// osiris_mem_arbiter
// Two-master, one-slave Wishbone classic arbiter in front of one memory.
// M0 is the RISC-V core port, M1 the UART-Wishbone bridge.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_* / m1_*              master ports (cyc, stb, we, adr, dat_w, sel in;
//                            dat_r, ack, err out)
//   s_*                      slave port toward the memory
//   o_grant [1:0]            registered one-hot owner, 00 = none
//   o_timeout_cnt [7:0]      saturating count of slave timeouts
// Behaviour summary:
//   - IDLE registers a round-robin grant, so the slave sees a request one
//     cycle after the master raises it.
//   - BUSY muxes the owner onto the slave combinationally, gated by the
//     owner's cyc, and holds the grant while cyc stays high (bus lock).
//   - A strobe left unanswered for TIMEOUT_CYCLES cycles produces a one-cycle
//     ERR state that returns err to the owner with the slave strobe removed.
// ---------------------------------------------------------------------------
module osiris_mem_arbiter
  import osiris_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,
  output logic                    m0_ack,
  output logic                    m0_err,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,
  output logic                    m1_ack,
  output logic                    m1_err,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH-1:0]   s_dat_w,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  input  logic [DATA_WIDTH-1:0]   s_dat_r,
  input  logic                    s_ack,
  input  logic                    s_err,

  output logic [1:0]              o_grant,
  output logic [7:0]              o_timeout_cnt
);

  localparam int unsigned SelW = DATA_WIDTH / 8;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("osiris_mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e      r_state;
  logic [1:0]      r_grant;
  logic            r_last;
  logic [CntW-1:0] r_to_cnt;
  logic [7:0]      r_timeout_cnt;

  logic [1:0]            w_req;
  logic [1:0]            w_pick;
  logic                  w_sel_uart;
  logic                  w_owned;
  logic                  w_g_cyc;
  logic                  w_g_stb;
  logic                  w_g_we;
  logic [ADDR_WIDTH-1:0] w_g_adr;
  logic [DATA_WIDTH-1:0] w_g_dat_w;
  logic [SelW-1:0]       w_g_sel;
  logic                  w_bus_on;
  logic                  w_in_err;
  logic [CntW-1:0]       w_cnt_inc;

  // -------------------------------------------------------------------------
  // Request vector and round-robin pick
  // -------------------------------------------------------------------------
  always_comb begin
    w_req           = 2'b00;
    w_req[GNT_CORE] = m0_cyc & m0_stb;
    w_req[GNT_UART] = m1_cyc & m1_stb;
  end

  osiris_rr_arbiter_2 u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // -------------------------------------------------------------------------
  // Owner mux
  // -------------------------------------------------------------------------
  assign w_sel_uart = r_grant[GNT_UART];
  assign w_owned    = |r_grant;

  assign w_g_cyc   = w_sel_uart ? m1_cyc   : m0_cyc;
  assign w_g_stb   = w_sel_uart ? m1_stb   : m0_stb;
  assign w_g_we    = w_sel_uart ? m1_we    : m0_we;
  assign w_g_adr   = w_sel_uart ? m1_adr   : m0_adr;
  assign w_g_dat_w = w_sel_uart ? m1_dat_w : m0_dat_w;
  assign w_g_sel   = w_sel_uart ? m1_sel   : m0_sel;

  // The owner's own cyc gates the slave, so an abort removes the request in
  // the same cycle; ERR is excluded so the slave sees the strobe drop.
  assign w_bus_on = (r_state == StBusy) && w_owned && w_g_cyc;
  assign w_in_err = (r_state == StErr) && w_owned;

  assign s_cyc   = w_bus_on;
  assign s_stb   = w_bus_on & w_g_stb;
  assign s_we    = w_bus_on & w_g_we;
  assign s_adr   = w_bus_on ? w_g_adr   : '0;
  assign s_dat_w = w_bus_on ? w_g_dat_w : '0;
  assign s_sel   = w_bus_on ? w_g_sel   : '0;

  // -------------------------------------------------------------------------
  // Response routing: only the owner sees the slave; a late ack after the
  // owner dropped cyc is swallowed because w_bus_on is already low.
  // -------------------------------------------------------------------------
  always_comb begin
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_r = '0;
    if (r_grant[GNT_CORE]) begin
      m0_ack = w_bus_on & s_ack;
      m0_err = (w_bus_on & s_err) | w_in_err;
      if (r_state == StBusy) begin
        m0_dat_r = s_dat_r;
      end
    end
    if (r_grant[GNT_UART]) begin
      m1_ack = w_bus_on & s_ack;
      m1_err = (w_bus_on & s_err) | w_in_err;
      if (r_state == StBusy) begin
        m1_dat_r = s_dat_r;
      end
    end
  end

  assign o_grant       = r_grant;
  assign o_timeout_cnt = r_timeout_cnt;

  assign w_cnt_inc = r_to_cnt + CntW'(1);

  // -------------------------------------------------------------------------
  // Arbiter FSM, timeout counter and timeout event counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_grant       <= 2'b00;
      r_last        <= 1'(GNT_CORE);  // M1 wins the first tie
      r_to_cnt      <= '0;
      r_timeout_cnt <= 8'd0;
    end else begin
      case (r_state)
        StIdle: begin
          r_to_cnt <= '0;
          if (|w_req) begin
            r_grant <= w_pick;
            r_state <= StBusy;
          end
        end

        StBusy: begin
          if (!w_g_cyc) begin
            r_state  <= StIdle;
            r_grant  <= 2'b00;
            r_last   <= w_sel_uart;
            r_to_cnt <= '0;
          end else if (!s_stb || s_ack || s_err) begin
            // A response in the same cycle as the limit wins over timeout.
            r_to_cnt <= '0;
          end else if (w_cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
            r_state  <= StErr;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= w_cnt_inc;
          end
        end

        StErr: begin
          r_to_cnt      <= '0;
          r_timeout_cnt <= sat_inc8(r_timeout_cnt);
          if (w_g_cyc) begin
            r_state <= StBusy;
          end else begin
            r_state <= StIdle;
            r_grant <= 2'b00;
            r_last  <= w_sel_uart;
          end
        end

        default: begin
          r_state  <= StIdle;
          r_grant  <= 2'b00;
          r_to_cnt <= '0;
        end
      endcase
    end
  end

endmodule
